gpio_to_mouse: RTL and testbench

- Receive-side stage for the inter-board button link.
- Consumes the registered left/right button levels that the partner board drives onto GPIO pins.
- Synchronises the asynchronous pins into the local clock domain, debounces them, and presents clean button levels plus one-cycle press/release pulses to local game/control logic.
- One instance per board, directly behind the GPIO input pins.

---
 rtl/gpio_to_mouse.sv | 78 +++++++
 tb/tb_gpio_to_mouse.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gpio_to_mouse.sv
// Receive side of the inter-board button link: synchronises the partner board's
// left/right GPIO levels, debounces them and emits one-cycle press/release pulses.
module gpio_to_mouse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic gpio_left_input,
    input  logic gpio_right_input,
    output logic m_left,
    output logic m_right,
    output logic left_press,
    output logic left_release,
    output logic right_press,
    output logic right_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] pin;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] release_p;

    assign pin = {gpio_right_input, gpio_left_input};

    // Channel 0 is left, channel 1 is right; the two never interact.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   synced;

        assign synced = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], pin[ch]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (synced == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Accept on the same edge the pulse is raised, so the pulse
                    // lines up with the first cycle showing the new level.
                    level_q   <= synced;
                    cnt_q     <= '0;
                    press_q   <= synced;
                    release_q <= ~synced;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign level[ch]     = level_q;
        assign press[ch]     = press_q;
        assign release_p[ch] = release_q;
    end

    assign m_left        = level[0];
    assign m_right       = level[1];
    assign left_press    = press[0];
    assign left_release  = release_p[0];
    assign right_press   = press[1];
    assign right_release = release_p[1];

endmodule

// File: tb/tb_gpio_to_mouse.sv
// Directed bench for gpio_to_mouse: scoreboard of expected level changes keyed by
// edge number, checked every cycle; a default-parameter instance checks full latency.
module tb_gpio_to_mouse;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left = 1'b0, right = 1'b0;
    logic left2 = 1'b0, right2 = 1'b0;

    logic m_left, m_right, left_press, left_release, right_press, right_release;
    logic m_left2, m_right2, left_press2, left_release2, right_press2, right_release2;

    always #5 clk = ~clk;

    gpio_to_mouse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .gpio_left_input(left), .gpio_right_input(right),
        .m_left(m_left), .m_right(m_right),
        .left_press(left_press), .left_release(left_release),
        .right_press(right_press), .right_release(right_release)
    );

    gpio_to_mouse dut_def (
        .clk(clk), .rst(rst),
        .gpio_left_input(left2), .gpio_right_input(right2),
        .m_left(m_left2), .m_right(m_right2),
        .left_press(left_press2), .left_release(left_release2),
        .right_press(right_press2), .right_release(right_release2)
    );

    typedef struct {
        int edge_no;
        int ch;
        bit rise;
    } ev_t;

    ev_t  sb[$];
    int   edge_n  = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [1:0] exp_lvl = 2'b00;
    logic [1:0] exp_p, exp_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Pin change driven now (after edge k) is accepted at edge k+SYNC+DEBOUNCE = k+6.
    task automatic expect_change(input int ch, input bit rise);
        ev_t e;
        e.edge_no = edge_n + 6;
        e.ch      = ch;
        e.rise    = rise;
        sb.push_back(e);
    endtask

    task automatic step();
        logic rst_at_edge;
        @(posedge clk);
        rst_at_edge = rst;
        edge_n++;
        @(negedge clk);
        if (rst_at_edge) begin
            exp_lvl = 2'b00;
            sb.delete();
        end
        exp_p = 2'b00;
        exp_r = 2'b00;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_no == edge_n) begin
                exp_lvl[sb[i].ch] = sb[i].rise;
                if (sb[i].rise) exp_p[sb[i].ch] = 1'b1;
                else            exp_r[sb[i].ch] = 1'b1;
                sb.delete(i);
            end
        end
        chk("m_left",        32'(m_left),        32'(exp_lvl[0]));
        chk("m_right",       32'(m_right),       32'(exp_lvl[1]));
        chk("left_press",    32'(left_press),    32'(exp_p[0]));
        chk("left_release",  32'(left_release),  32'(exp_r[0]));
        chk("right_press",   32'(right_press),   32'(exp_p[1]));
        chk("right_release", 32'(right_release), 32'(exp_r[1]));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int found;
        logic lvl_before;

        // Reset and idle
        @(negedge clk);
        steps(3);
        rst = 1'b0;
        steps(20);

        // Left press, then left release
        left = 1'b1; expect_change(0, 1'b1);
        steps(10);
        left = 1'b0; expect_change(0, 1'b0);
        steps(10);

        // Right glitch of 3 cycles is rejected
        right = 1'b1;
        steps(3);
        right = 1'b0;
        steps(10);

        // Right high for exactly 4 cycles: one press then one release
        right = 1'b1; expect_change(1, 1'b1);
        steps(4);
        right = 1'b0; expect_change(1, 1'b0);
        steps(12);

        // Both channels on the same edge
        left = 1'b1; right = 1'b1;
        expect_change(0, 1'b1); expect_change(1, 1'b1);
        steps(10);
        left = 1'b0; right = 1'b0;
        expect_change(0, 1'b0); expect_change(1, 1'b0);
        steps(10);

        // Reset mid-debounce with the pin held high
        left = 1'b1;
        steps(3);
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        expect_change(0, 1'b1);
        steps(12);
        left = 1'b0; expect_change(0, 1'b0);
        steps(10);

        // Steady state: no pulses
        steps(20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Default parameters: press appears at edge 65002, not before
        left2 = 1'b1;
        found = 0;
        lvl_before = 1'bx;
        for (int i = 1; i <= 65010 && found == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 65001) lvl_before = m_left2;
            if (left_press2) found = i;
        end
        chk("default_level_before", 32'(lvl_before), 32'd0);
        chk("default_press_edge", 32'(found), 32'd65002);
        chk("default_level_after", 32'(m_left2), 32'd1);
        chk("default_right_idle", 32'(m_right2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
